huffman_encoder: RTL and testbench

Serial Huffman encoder, the transmit-side counterpart of the team's huffman_decoder. Accepts 3-bit symbols over a valid/ready handshake and buffers them in a small FIFO. Emits the prefix code one bit per cycle, MSB (first-transmitted bit) first, on a serial output whose bit stream the decoder consumes directly. Code table: sym 1="0", 2="101", 3="100", 4="111", 5="1101", 6="1100"; symbols 0 and 7 are illegal.

---
 rtl/huffman_encoder_if.sv | 26 ++
 rtl/huffman_encoder.sv | 170 +++++++++++++++++
 tb/tb_huffman_encoder.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/huffman_encoder_if.sv
// Symbol-in / serial-bit-out bundle of the Huffman encoder.
// The encoder connects through the slave modport; its driver/consumer uses master.
interface huffman_encoder_if #(
   parameter int LVL_W = 3
);
   logic [2:0]       sym_in;
   logic             sym_valid;
   logic             sym_ready;
   logic             bit_out;
   logic             bit_valid;
   logic             bit_ready;
   logic             bit_last;
   logic             err;
   logic [LVL_W-1:0] fifo_level;
   logic             busy;

   modport master (
      output sym_in, sym_valid, bit_ready,
      input  sym_ready, bit_out, bit_valid, bit_last, err, fifo_level, busy
   );

   modport slave (
      input  sym_in, sym_valid, bit_ready,
      output sym_ready, bit_out, bit_valid, bit_last, err, fifo_level, busy
   );
endinterface

// File: rtl/huffman_encoder.sv
// Serial Huffman encoder: buffers 3-bit symbols in a small FIFO and shifts
// out their prefix codes MSB first, one bit per accepted cycle.
// Codes: 1="0", 2="101", 3="100", 4="111", 5="1101", 6="1100"; 0 and 7 flag err.
module huffman_encoder #(
   parameter int FIFO_DEPTH = 4,
   parameter int LVL_W      = 3
) (
   input  logic               clk,
   input  logic               reset,
   huffman_encoder_if.slave   enc_if
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Code word left-aligned in [5:2] (first bit at [5]) and length-1 in [1:0].
   function automatic logic [5:0] code_of(input logic [2:0] sym);
      logic [5:0] c;
      case (sym)
         3'd1:    c = {4'b0000, 2'd0};
         3'd2:    c = {4'b1010, 2'd2};
         3'd3:    c = {4'b1000, 2'd2};
         3'd4:    c = {4'b1110, 2'd2};
         3'd5:    c = {4'b1101, 2'd3};
         3'd6:    c = {4'b1100, 2'd3};
         default: c = 6'b000000;
      endcase
      return c;
   endfunction

   state_t           state_q, state_d;
   logic [2:0]       fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [3:0]       shreg_q, shreg_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             last_q, last_d;
   logic             err_q, err_d;

   logic             sym_ready_s;
   logic             sym_legal_s;
   logic             accept_s;
   logic             push_s;
   logic             pop_s;
   logic             empty_s;
   logic [5:0]       head_code_s;

   // No pass-through: a full FIFO refuses input even when a pop happens this cycle.
   assign sym_ready_s = (level_q != LVL_W'(FIFO_DEPTH));
   assign sym_legal_s = (enc_if.sym_in != 3'd0) && (enc_if.sym_in != 3'd7);
   assign accept_s    = enc_if.sym_valid && sym_ready_s;
   assign push_s      = accept_s && sym_legal_s;
   assign empty_s     = (level_q == {LVL_W{1'b0}});
   assign head_code_s = code_of(fifo_mem_q[rd_ptr_q]);

   // Serializer next state, shift register update, pops and FIFO bookkeeping.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      pop_s    = 1'b0;
      err_d    = accept_s && !sym_legal_s;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;

      case (state_q)
         ST_IDLE: begin
            if (!empty_s) begin
               pop_s   = 1'b1;
               shreg_d = head_code_s[5:2];
               cnt_d   = head_code_s[1:0];
               last_d  = (head_code_s[1:0] == 2'd0);
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (enc_if.bit_ready) begin
               if (last_q) begin
                  if (!empty_s) begin
                     // Back-to-back follower: load the next code with no bubble.
                     pop_s   = 1'b1;
                     shreg_d = head_code_s[5:2];
                     cnt_d   = head_code_s[1:0];
                     last_d  = (head_code_s[1:0] == 2'd0);
                     state_d = ST_SHIFT;
                  end else begin
                     shreg_d = 4'b0000;
                     cnt_d   = 2'd0;
                     last_d  = 1'b0;
                     state_d = ST_IDLE;
                  end
               end else begin
                  shreg_d = {shreg_q[2:0], 1'b0};
                  cnt_d   = cnt_q - 2'd1;
                  last_d  = (cnt_q == 2'd1);
               end
            end else begin
               state_d = ST_SHIFT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // State, pointers, level and serializer registers with synchronous flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         level_q  <= {LVL_W{1'b0}};
         shreg_q  <= 4'b0000;
         cnt_q    <= 2'd0;
         last_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         err_q    <= err_d;
      end
   end

   // Symbol storage; contents are don't-care until written, the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_s && !reset) begin
         fifo_mem_q[wr_ptr_q] <= enc_if.sym_in;
      end
   end

   assign enc_if.sym_ready  = sym_ready_s;
   assign enc_if.bit_out    = shreg_q[3];
   assign enc_if.bit_valid  = (state_q == ST_SHIFT);
   assign enc_if.bit_last   = last_q;
   assign enc_if.err        = err_q;
   assign enc_if.fifo_level = level_q;
   assign enc_if.busy       = (state_q == ST_SHIFT) || !empty_s;
endmodule

// File: tb/tb_huffman_encoder.sv
// Scoreboard bench for huffman_encoder: accepted symbols are expanded into
// expected code bits from a plain code table; a monitor pops and compares
// every transferred bit and tracks err, fifo_level, sym_ready and busy.
module tb_huffman_encoder;
   logic clk;
   logic reset;

   huffman_encoder_if #(.LVL_W(3)) bus ();

   huffman_encoder #(.FIFO_DEPTH(4), .LVL_W(3)) dut (
      .clk    (clk),
      .reset  (reset),
      .enc_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference code table: code value right-aligned, first bit is the MSB of len bits.
   int code_val [8] = '{0, 0, 5, 4, 7, 13, 12, 0};
   int code_len [8] = '{0, 1, 3, 3, 3, 4, 4, 0};

   int total = 0;
   int bad   = 0;

   logic [1:0] exp_q [$];     // {bit, last}
   bit   lvl_chk = 1'b0;
   int   lvl_exp = 0;
   bit   err_exp = 1'b0;
   bit   hold_v = 1'b0;
   logic hold_bit, hold_last;
   int   xfer_cnt = 0;
   int   last_cnt = 0;
   int   run_cnt = 0;
   int   max_run = 0;
   int   sim_pp = 0;
   bit   rand_rdy = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic report_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout/unexpected event expected normal completion at %0t", name, $time);
   endtask

   // Monitor: compares at the falling edge, then forms expectations for the next rising edge.
   initial begin
      logic [1:0] e;
      bit xfer, acc, legal, pop;
      int s;
      forever begin
         @(negedge clk);
         if (lvl_chk) begin
            check("fifo_level", int'(bus.fifo_level), lvl_exp);
            check("sym_ready", int'(bus.sym_ready), int'(lvl_exp != 4));
            check("busy", int'(bus.busy), int'(bus.bit_valid || (lvl_exp != 0)));
            check("err", int'(bus.err), int'(err_exp));
         end
         if (hold_v) begin
            check("stall_valid", int'(bus.bit_valid), 1);
            check("stall_bit", int'(bus.bit_out), int'(hold_bit));
            check("stall_last", int'(bus.bit_last), int'(hold_last));
         end
         if (bus.bit_valid) begin
            run_cnt++;
            if (run_cnt > max_run) max_run = run_cnt;
         end else begin
            run_cnt = 0;
         end

         if (reset) begin
            exp_q.delete();
            lvl_chk = 1'b1;
            lvl_exp = 0;
            err_exp = 1'b0;
            hold_v  = 1'b0;
         end else begin
            xfer = bus.bit_valid && bus.bit_ready;
            if (xfer) begin
               xfer_cnt++;
               if (bus.bit_last) last_cnt++;
               if (exp_q.size() == 0) begin
                  report_fail("unexpected_bit");
               end else begin
                  e = exp_q.pop_front();
                  check("bit_out", int'(bus.bit_out), int'(e[1]));
                  check("bit_last", int'(bus.bit_last), int'(e[0]));
               end
            end
            hold_v    = bus.bit_valid && !bus.bit_ready;
            hold_bit  = bus.bit_out;
            hold_last = bus.bit_last;

            s     = int'(bus.sym_in);
            acc   = bus.sym_valid && bus.sym_ready;
            legal = acc && (s >= 1) && (s <= 6);
            if (legal) begin
               for (int i = code_len[s] - 1; i >= 0; i--) begin
                  exp_q.push_back({code_val[s][i], (i == 0) ? 1'b1 : 1'b0});
               end
            end
            err_exp = acc && !legal;
            pop = (lvl_exp != 0) && (!bus.bit_valid || (xfer && bus.bit_last));
            if (legal && pop && lvl_exp == 2) sim_pp++;
            lvl_exp = lvl_exp + (legal ? 1 : 0) - (pop ? 1 : 0);
         end
      end
   end

   // Random back-pressure generator, active only during the random phase.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) bus.bit_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] s);
      int n;
      n = 0;
      bus.sym_in    = s;
      bus.sym_valid = 1'b1;
      @(negedge clk);
      while (!bus.sym_ready && n < 500) begin
         n++;
         @(negedge clk);
      end
      if (n >= 500) report_fail("send_timeout");
      step();
      bus.sym_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || bus.busy) && n < 3000) begin
         n++;
         @(negedge clk);
      end
      if (n >= 3000) report_fail("drain_timeout");
      step();
   endtask

   task automatic wait_xfer(input int target);
      int n;
      n = 0;
      while (xfer_cnt < target && n < 200) begin
         n++;
         @(posedge clk);
      end
      if (n >= 200) report_fail("xfer_wait_timeout");
      #1;
   endtask

   initial begin
      int base, lbase;
      logic [2:0] s;
      reset         = 1'b1;
      bus.sym_in    = 3'd0;
      bus.sym_valid = 1'b0;
      bus.bit_ready = 1'b1;
      repeat (2) step();
      reset = 1'b0;

      // Reset values.
      @(negedge clk);
      check("rst_bit_out", int'(bus.bit_out), 0);
      check("rst_bit_valid", int'(bus.bit_valid), 0);
      check("rst_bit_last", int'(bus.bit_last), 0);
      check("rst_sym_ready", int'(bus.sym_ready), 1);
      step();

      // Latency: accepted at edge N, popped at N+1, first bit after N+1.
      send(3'd3);
      @(negedge clk);
      check("lat_valid_n", int'(bus.bit_valid), 0);
      check("lat_level_n", int'(bus.fifo_level), 1);
      @(negedge clk);
      check("lat_valid_n1", int'(bus.bit_valid), 1);
      check("lat_first_bit", int'(bus.bit_out), 1);
      step();
      drain();

      // Back-to-back 1..6: 18 continuous bits, 6 code ends.
      base = xfer_cnt; lbase = last_cnt; max_run = 0;
      for (int i = 1; i <= 6; i++) send(3'(i));
      drain();
      check("b2b_bits", xfer_cnt - base, 18);
      check("b2b_lasts", last_cnt - lbase, 6);
      check("b2b_run", max_run, 18);

      // Stall five cycles mid code 5 after its second bit.
      base = xfer_cnt;
      send(3'd5);
      wait_xfer(base + 2);
      bus.bit_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("stall_hold_valid", int'(bus.bit_valid), 1);
      end
      check("stall_no_xfer", xfer_cnt - base, 2);
      step();
      bus.bit_ready = 1'b1;
      drain();
      check("stall_total_bits", xfer_cnt - base, 4);

      // Full FIFO: 1 in serializer + 4 buffered, 6th refused until a pop.
      base = xfer_cnt;
      bus.bit_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(3'd4);
      bus.sym_in    = 3'd4;
      bus.sym_valid = 1'b1;
      @(negedge clk);
      check("full_ready", int'(bus.sym_ready), 0);
      check("full_level", int'(bus.fifo_level), 4);
      step();
      bus.bit_ready = 1'b1;
      send(3'd4);
      drain();
      check("full_bits", xfer_cnt - base, 18);

      // Illegal symbols are consumed, flagged and never emitted.
      base = xfer_cnt;
      send(3'd0);
      @(negedge clk);
      check("ill0_err", int'(bus.err), 1);
      check("ill0_level", int'(bus.fifo_level), 0);
      step();
      send(3'd7);
      @(negedge clk);
      check("ill7_err", int'(bus.err), 1);
      step();
      send(3'd1);
      drain();
      check("ill_bits", xfer_cnt - base, 1);

      // Reset mid-code discards code 5 remainder and queued 6.
      base = xfer_cnt;
      send(3'd5);
      send(3'd6);
      wait_xfer(base + 2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      check("mrst_valid", int'(bus.bit_valid), 0);
      check("mrst_level", int'(bus.fifo_level), 0);
      check("mrst_busy", int'(bus.busy), 0);
      check("mrst_ready", int'(bus.sym_ready), 1);
      step();
      base = xfer_cnt;
      send(3'd3);
      drain();
      check("mrst_after_bits", xfer_cnt - base, 3);

      // Simultaneous push/pop at level 2, then mixed order across pointer wrap.
      bus.bit_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(3'd1);
      bus.bit_ready = 1'b1;
      sim_pp = 0;
      for (int i = 0; i < 10; i++) send(3'd1);
      check("pushpop_lvl2", sim_pp, 10);
      for (int i = 0; i < 10; i++) send(3'(1 + (i * 5) % 6));
      drain();

      // Random phase with back-pressure and occasional illegal symbols.
      rand_rdy = 1'b1;
      for (int i = 0; i < 150; i++) begin
         s = 3'($urandom_range(0, 7));
         send(s);
         repeat ($urandom_range(0, 2)) step();
      end
      rand_rdy = 1'b0;
      step();
      bus.bit_ready = 1'b1;
      drain();
      check("final_queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1);
   end
endmodule
